// File: rtl/cdc_handshake_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx_if
// Description : Source valid/ready bus plus toggle request/acknowledge CDC bus
// Revision    : 1.0 - initial release
// ============================================================================
interface cdc_handshake_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] src_data;
    logic                 src_valid;
    logic                 src_ready;
    logic [BUS_WIDTH-1:0] tx_data;
    logic                 tx_req;
    logic                 rx_ack;
    logic                 busy;
    logic                 done;
    logic                 err;

    // master = source plus far-domain environment, slave = the transmitter
    modport master (
        output src_data, src_valid, rx_ack,
        input  src_ready, tx_data, tx_req, busy, done, err
    );

    modport slave (
        input  src_data, src_valid, rx_ack,
        output src_ready, tx_data, tx_req, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Transmit end of a toggle req/ack multi-bit clock-domain crossing
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cdc_handshake_tx_if.slave  bus
);

    localparam int SYNC_STAGES = (NUM_STAGES < 2) ? 2 : NUM_STAGES;
    localparam int TO_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GAP_W       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_GAP      = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    w_ack_s;
    logic [BUS_WIDTH-1:0]    r_tx_data;
    logic [BUS_WIDTH-1:0]    w_tx_data_nxt;
    logic                    r_tx_req;
    logic                    w_tx_req_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_err;
    logic                    w_err_nxt;
    logic [TO_W-1:0]         r_tcnt;
    logic [TO_W-1:0]         w_tcnt_nxt;
    logic [GAP_W-1:0]        r_gcnt;
    logic [GAP_W-1:0]        w_gcnt_nxt;

    // rx_ack is asynchronous to clk; only the last stage is ever observed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.rx_ack};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
            r_tx_req  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
            r_gcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_req  <= w_tx_req_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_gcnt    <= w_gcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_tx_req_nxt  = r_tx_req;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_tcnt_nxt    = r_tcnt;
        w_gcnt_nxt    = r_gcnt;

        case (r_state)
            S_IDLE: begin
                // A settled link always has ack_s equal to tx_req while idle
                if (w_ack_s != r_tx_req) begin
                    w_err_nxt = 1'b1;
                end
                if (bus.src_valid) begin
                    w_tx_data_nxt = bus.src_data;
                    w_tx_req_nxt  = ~r_tx_req;
                    w_tcnt_nxt    = '0;
                    w_state_nxt   = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                if (w_ack_s == r_tx_req) begin
                    w_done_nxt  = 1'b1;
                    w_gcnt_nxt  = '0;
                    w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (r_tcnt != TO_LIMIT)) begin
                    // Keep waiting after a timeout: aborting would break toggle parity
                    w_tcnt_nxt = r_tcnt + TO_W'(1);
                    if (w_tcnt_nxt == TO_LIMIT) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (r_gcnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.src_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_req    = r_tx_req;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_tx
// Description : Directed scoreboard bench for cdc_handshake_tx
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    logic clk;
    logic rst;

    typedef struct packed {
        logic [7:0] data;
        logic       req;
    } exp_t;

    exp_t exp_q[$];
    logic exp_req;
    int   errors;
    int   checks;
    int   done_cnt;

    cdc_handshake_tx_if #(.BUS_WIDTH(8)) bus ();

    cdc_handshake_tx #(
        .BUS_WIDTH      (8),
        .NUM_STAGES     (2),
        .GAP_CYCLES     (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse retires the oldest expected transfer
    always @(negedge clk) begin
        if (rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.tx_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_tx_data", 32'(bus.tx_data), 32'(e.data));
                check("done_tx_req", 32'(bus.tx_req), 32'(e.req));
            end
        end
    end

    task automatic push_exp(input logic [7:0] d);
        exp_req = ~exp_req;
        exp_q.push_back('{data: d, req: exp_req});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'h0);
        check({tag, "_tx_req"}, 32'(bus.tx_req), 32'h0);
        check({tag, "_done"}, 32'(bus.done), 32'h0);
        check({tag, "_err"}, 32'(bus.err), 32'h0);
        check({tag, "_src_ready"}, 32'(bus.src_ready), 32'h1);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data  = 8'h00;
        bus.rx_ack    = 1'b0;
        exp_q.delete();
        exp_req = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 60), 32'h1);
    endtask

    // Present a word, wait for acceptance, then echo tx_req after dly cycles (dly<0: no ack)
    task automatic xfer(input logic [7:0] d, input int dly);
        int n = 0;
        bus.src_data  = d;
        bus.src_valid = 1'b1;
        push_exp(d);
        while (!bus.src_ready && n < 40) begin
            tick();
            n++;
        end
        check("accept_timeout", 32'(n < 40), 32'h1);
        tick();
        bus.src_valid = 1'b0;
        check("acc_tx_data", 32'(bus.tx_data), 32'(d));
        check("acc_tx_req", 32'(bus.tx_req), 32'(exp_req));
        if (dly >= 0) begin
            repeat (dly) tick();
            bus.rx_ack = bus.tx_req;
        end
    endtask

    initial begin
        int dc;
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        exp_req  = 1'b0;
        rst      = 1'b1;
        #2;
        apply_reset();

        // Single transfer 0xA5 with latency checks; 0xFF offered while busy
        bus.src_data  = 8'hA5;
        bus.src_valid = 1'b1;
        push_exp(8'hA5);
        tick();
        bus.src_valid = 1'b0;
        check("t1_tx_data", 32'(bus.tx_data), 32'hA5);
        check("t1_tx_req", 32'(bus.tx_req), 32'h1);
        check("t1_src_ready", 32'(bus.src_ready), 32'h0);
        check("t1_busy", 32'(bus.busy), 32'h1);
        bus.rx_ack    = 1'b1;
        bus.src_data  = 8'hFF;
        bus.src_valid = 1'b1;
        push_exp(8'hFF);
        tick();
        check("t1_done_e1", 32'(bus.done), 32'h0);
        check("t1_hold_e1", 32'(bus.tx_data), 32'hA5);
        tick();
        check("t1_done_e2", 32'(bus.done), 32'h0);
        tick();
        check("t1_done_e3", 32'(bus.done), 32'h1);
        check("t1_hold_e3", 32'(bus.tx_data), 32'hA5);
        check("t1_gap_ready", 32'(bus.src_ready), 32'h0);
        check("t1_gap_busy", 32'(bus.busy), 32'h1);
        tick();
        check("t1_done_e4", 32'(bus.done), 32'h0);
        check("t1_idle_ready", 32'(bus.src_ready), 32'h1);
        check("t1_idle_busy", 32'(bus.busy), 32'h0);
        check("t1_hold_e4", 32'(bus.tx_data), 32'hA5);
        tick();
        bus.src_valid = 1'b0;
        check("t3_tx_data", 32'(bus.tx_data), 32'hFF);
        check("t3_tx_req", 32'(bus.tx_req), 32'h0);
        bus.rx_ack = 1'b0;
        wait_idle();

        // Back-to-back words with a 4-cycle echo responder
        dc = done_cnt;
        xfer(8'h11, 4);
        xfer(8'h22, 4);
        wait_idle();
        tick();
        check("t2_done_count", 32'(done_cnt - dc), 32'd2);
        check("t2_err", 32'(bus.err), 32'h0);

        // Timeout: no acknowledge for 8 WAIT_ACK cycles, then a late ack
        xfer(8'h3C, -1);
        repeat (7) tick();
        check("t4_err_e7", 32'(bus.err), 32'h0);
        tick();
        check("t4_err_e8", 32'(bus.err), 32'h1);
        repeat (4) tick();
        check("t4_still_busy", 32'(bus.busy), 32'h1);
        check("t4_err_sticky", 32'(bus.err), 32'h1);
        bus.rx_ack = bus.tx_req;
        wait_idle();
        check("t4_err_after_done", 32'(bus.err), 32'h1);
        apply_reset();

        // Spurious acknowledge while idle
        dc = done_cnt;
        bus.rx_ack = 1'b1;
        tick();
        tick();
        check("t5_err_e2", 32'(bus.err), 32'h0);
        tick();
        check("t5_err_e3", 32'(bus.err), 32'h1);
        check("t5_tx_req", 32'(bus.tx_req), 32'h0);
        check("t5_busy", 32'(bus.busy), 32'h0);
        tick();
        check("t5_no_done", 32'(done_cnt - dc), 32'd0);
        apply_reset();

        // Asynchronous reset in the middle of WAIT_ACK, then a fresh transfer
        xfer(8'h5A, -1);
        repeat (2) tick();
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("t6_async");
        apply_reset();
        dc = done_cnt;
        xfer(8'hC3, 2);
        wait_idle();
        tick();
        check("t6_done_count", 32'(done_cnt - dc), 32'd1);
        check("t6_err", 32'(bus.err), 32'h0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_done_total", 32'(done_cnt), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
